// File: rtl/alarm_ringer.sv
// Alarm ringer: match live time against alarm, ring/snooze/stop/timeout.
// Optional ALARM_BEEP_PATTERN_EN: buzz toggles once per second while ringing.
module alarm_ringer #(
  parameter int SNOOZE_MIN   = 5,
  parameter int MAX_SNOOZE   = 3,
  parameter int RING_TIMEOUT = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic [5:0] cur_hr,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [5:0] alm_hr,
  input  logic [5:0] alm_min,
  input  logic       almen,
  input  logic       stop,
  input  logic       snooze,
  output logic       ringing,
  output logic       buzz,
  output logic       snooze_act,
  output logic [1:0] snooze_cnt
);

  typedef enum logic [1:0] {
    IDLE, ARMED, RINGING, SNOOZE
  } state_t;

  state_t     state, state_d;
  logic [5:0] tgt_hr, tgt_min;
  logic [5:0] tgt_hr_d, tgt_min_d;
  logic [5:0] cmp_hr, cmp_min;
  logic [5:0] sn_hr, sn_min;
  logic [6:0] m_sum;
  logic [7:0] ring_cnt, ring_cnt_d;
  logic [1:0] snooze_cnt_d;
  logic       buzz_d;
  logic       match, timeout, snz_max;

  // ARMED tracks the setter live so a freshly armed alarm needs no warm-up
  assign cmp_hr  = (state == ARMED) ? alm_hr  : tgt_hr;
  assign cmp_min = (state == ARMED) ? alm_min : tgt_min;

  assign match = sec_tick && (cur_sec == 6'd0)
              && (cmp_hr == cur_hr) && (cmp_min == cur_min)
              && (cmp_hr <= 6'd23) && (cmp_min <= 6'd59);

  assign timeout = sec_tick
                && (ring_cnt == 8'(RING_TIMEOUT - 1));
  assign snz_max = (snooze_cnt >= 2'(MAX_SNOOZE));

  always_comb begin
    m_sum  = {1'b0, cur_min} + 7'(SNOOZE_MIN);
    sn_min = m_sum[5:0];
    sn_hr  = cur_hr;
    if (m_sum >= 7'd60) begin
      sn_min = 6'(m_sum - 7'd60);
      sn_hr  = (cur_hr == 6'd23) ? 6'd0 : cur_hr + 6'd1;
    end
  end

  always_comb begin
    state_d      = state;
    tgt_hr_d     = tgt_hr;
    tgt_min_d    = tgt_min;
    ring_cnt_d   = ring_cnt;
    snooze_cnt_d = snooze_cnt;
    if (!almen) begin
      state_d      = IDLE;
      snooze_cnt_d = 2'd0;
    end else begin
      unique case (state)
        IDLE: state_d = ARMED;
        ARMED: begin
          tgt_hr_d  = alm_hr;
          tgt_min_d = alm_min;
          if (match) begin
            state_d    = RINGING;
            ring_cnt_d = 8'd0;
          end
        end
        RINGING: begin
          if (stop || (snooze && snz_max)) begin
            state_d      = ARMED;
            snooze_cnt_d = 2'd0;
          end else if (snooze) begin
            state_d      = SNOOZE;
            snooze_cnt_d = snooze_cnt + 2'd1;
            tgt_hr_d     = sn_hr;
            tgt_min_d    = sn_min;
          end else if (timeout) begin
            state_d      = ARMED;
            snooze_cnt_d = 2'd0;
          end else if (sec_tick) begin
            ring_cnt_d = ring_cnt + 8'd1;
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_d      = ARMED;
            snooze_cnt_d = 2'd0;
          end else if (match) begin
            state_d    = RINGING;
            ring_cnt_d = 8'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
`ifdef ALARM_BEEP_PATTERN_EN
    buzz_d = 1'b0;
    if (state_d == RINGING) begin
      if (state != RINGING) buzz_d = 1'b1;
      else if (sec_tick)    buzz_d = ~buzz;
      else                  buzz_d = buzz;
    end
`else
    buzz_d = (state_d == RINGING);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      tgt_hr     <= 6'd0;
      tgt_min    <= 6'd0;
      ring_cnt   <= 8'd0;
      snooze_cnt <= 2'd0;
      ringing    <= 1'b0;
      buzz       <= 1'b0;
      snooze_act <= 1'b0;
    end else begin
      state      <= state_d;
      tgt_hr     <= tgt_hr_d;
      tgt_min    <= tgt_min_d;
      ring_cnt   <= ring_cnt_d;
      snooze_cnt <= snooze_cnt_d;
      ringing    <= (state_d == RINGING);
      buzz       <= buzz_d;
      snooze_act <= (state_d == SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_ringer.sv
// Bench for alarm_ringer: vector table, corner sequences,
// and random traffic against a minute-of-day reference model.
module tb_alarm_ringer;

  localparam int SN = 5;
  localparam int MX = 3;
  localparam int TO = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sec_tick = 1'b0;
  logic [5:0] cur_hr = '0, cur_min = '0, cur_sec = '0;
  logic [5:0] alm_hr = '0, alm_min = '0;
  logic       almen = 1'b0, stop = 1'b0, snooze = 1'b0;
  logic       ringing, buzz, snooze_act;
  logic [1:0] snooze_cnt;

  always #5 clk = ~clk;

  alarm_ringer #(
    .SNOOZE_MIN(SN), .MAX_SNOOZE(MX), .RING_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick),
    .cur_hr(cur_hr), .cur_min(cur_min), .cur_sec(cur_sec),
    .alm_hr(alm_hr), .alm_min(alm_min), .almen(almen),
    .stop(stop), .snooze(snooze),
    .ringing(ringing), .buzz(buzz),
    .snooze_act(snooze_act), .snooze_cnt(snooze_cnt)
  );

  int total = 0;
  int bad = 0;
  int now = 0;
  bit chk_model = 0;

  // reference: 0 idle, 1 armed, 2 ringing, 3 snoozing
  int m_mode = 0, m_tgt = 0, m_snz = 0, m_rsec = 0;
  bit m_buzz = 0;

  typedef struct {
    bit en; bit sp; bit sz; bit tk;
    int t; int ah; int am;
    bit er; bit es; int ec;
  } vec_t;

  vec_t tbl[14];

  function automatic int T(int h, int m, int s);
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic set_time(int t);
    now     = t;
    cur_hr  = 6'(t / 3600);
    cur_min = 6'((t / 60) % 60);
    cur_sec = 6'(t % 60);
  endtask

  task automatic model_step();
    int  nm;
    bit  top;
    nm  = now / 60;
    top = sec_tick && (now % 60 == 0);
    if (!rst_n) begin
      m_mode = 0; m_snz = 0; m_rsec = 0; m_buzz = 0; m_tgt = 0;
    end else if (!almen) begin
      m_mode = 0; m_snz = 0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: if (top && alm_hr < 24 && alm_min < 60
               && nm == int'(alm_hr) * 60 + int'(alm_min)) begin
             m_mode = 2; m_rsec = 0; m_buzz = 1;
           end
        2: if (stop || (snooze && m_snz == MX)) begin
             m_mode = 1; m_snz = 0;
           end else if (snooze) begin
             m_mode = 3; m_snz++; m_tgt = (nm + SN) % 1440;
           end else if (sec_tick) begin
             m_rsec++;
             if (m_rsec == TO) begin
               m_mode = 1; m_snz = 0;
             end else m_buzz = !m_buzz;
           end
        default: if (stop) begin
             m_mode = 1; m_snz = 0;
           end else if (top && nm == m_tgt) begin
             m_mode = 2; m_rsec = 0; m_buzz = 1;
           end
      endcase
    end
    if (m_mode != 2) m_buzz = 0;
  endtask

  task automatic step(bit tk, bit sp, bit sz);
    int e, eb;
    sec_tick = tk; stop = sp; snooze = sz;
    @(posedge clk);
    model_step();
    #1;
    sec_tick = 0; stop = 0; snooze = 0;
    if (chk_model) begin
`ifdef ALARM_BEEP_PATTERN_EN
      eb = int'(m_buzz);
`else
      eb = (m_mode == 2) ? 1 : 0;
`endif
      e = ((m_mode == 2) ? 16 : 0) + eb * 8
        + ((m_mode == 3) ? 4 : 0) + m_snz;
      chk("model", int'({ringing, buzz, snooze_act, snooze_cnt}), e);
    end
  endtask

  task automatic tick_at(int t);
    set_time(t);
    step(1, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    step(0, 0, 0);
    rst_n = 1;
  endtask

  task automatic set_alm(int h, int m);
    alm_hr  = 6'(h);
    alm_min = 6'(m);
  endtask

  initial begin
    bit rang;

    tbl[0]  = '{1,0,0,0, T(7,29,59), 7,30, 0,0,0};
    tbl[1]  = '{1,0,0,1, T(7,29,59), 7,30, 0,0,0};
    tbl[2]  = '{1,0,0,1, T(7,30,0),  7,30, 1,0,0};
    tbl[3]  = '{1,0,0,0, T(7,30,0),  7,30, 1,0,0};
    tbl[4]  = '{1,1,0,0, T(7,30,0),  7,30, 0,0,0};
    tbl[5]  = '{1,0,0,1, T(7,30,1),  7,31, 0,0,0};
    tbl[6]  = '{1,0,0,1, T(7,31,0),  7,31, 1,0,0};
    tbl[7]  = '{1,1,1,0, T(7,31,0),  7,31, 0,0,0};
    tbl[8]  = '{1,0,0,1, T(7,31,1),  7,32, 0,0,0};
    tbl[9]  = '{1,0,0,1, T(7,32,0),  7,32, 1,0,0};
    tbl[10] = '{1,0,1,0, T(7,32,0),  7,32, 0,1,1};
    tbl[11] = '{0,0,0,0, T(7,32,0),  7,32, 0,0,0};
    tbl[12] = '{1,0,0,0, T(7,32,0),  7,32, 0,0,0};
    tbl[13] = '{1,0,0,1, T(7,37,0),  7,32, 0,0,0};

    do_reset();
    chk("reset", int'({ringing, buzz, snooze_act, snooze_cnt}), 0);

    // stop, stop+snooze, and almen drop during snooze
    for (int i = 0; i < 14; i++) begin
      almen = tbl[i].en;
      set_alm(tbl[i].ah, tbl[i].am);
      set_time(tbl[i].t);
      step(tbl[i].tk, tbl[i].sp, tbl[i].sz);
      chk($sformatf("tbl%0d ring", i), int'(ringing), int'(tbl[i].er));
      chk($sformatf("tbl%0d sact", i), int'(snooze_act), int'(tbl[i].es));
      chk($sformatf("tbl%0d scnt", i), int'(snooze_cnt), tbl[i].ec);
      if (i == 2) chk("tbl2 buzz", int'(buzz), 1);
    end

    // snooze across midnight, then exhaust snoozes
    do_reset();
    almen = 1;
    set_alm(23, 58);
    set_time(T(23, 57, 59));
    step(0, 0, 0);
    tick_at(T(23, 58, 0));
    chk("wrap ring", int'(ringing), 1);
    step(0, 0, 1);
    chk("wrap sact", int'(snooze_act), 1);
    chk("wrap scnt", int'(snooze_cnt), 1);
    chk("wrap ring off", int'(ringing), 0);
    tick_at(T(0, 2, 0));
    chk("wrap early", int'(ringing), 0);
    tick_at(T(0, 3, 0));
    chk("wrap rering", int'(ringing), 1);
    chk("wrap rering cnt", int'(snooze_cnt), 1);
    step(0, 0, 1);
    chk("snz2 cnt", int'(snooze_cnt), 2);
    tick_at(T(0, 8, 0));
    chk("snz2 ring", int'(ringing), 1);
    step(0, 0, 1);
    chk("snz3 cnt", int'(snooze_cnt), 3);
    tick_at(T(0, 13, 0));
    chk("snz3 ring", int'(ringing), 1);
    step(0, 0, 1);
    chk("snz4 as stop",
        int'({ringing, snooze_act, snooze_cnt}), 0);
    tick_at(T(0, 18, 0));
    chk("snz4 no rering", int'(ringing), 0);

    // timeout after 60 ticks, then nothing until next day
    set_alm(7, 30);
    step(0, 0, 0);
    tick_at(T(7, 30, 0));
    chk("to rise", int'(ringing), 1);
    for (int s = 1; s < 60; s++) tick_at(T(7, 30, s));
    chk("to tick59", int'(ringing), 1);
    tick_at(T(7, 31, 0));
    chk("to tick60", int'(ringing), 0);
    chk("to scnt", int'(snooze_cnt), 0);
    rang = 0;
    for (int m = 7 * 60 + 31; m < 1440 + 7 * 60 + 30; m++) begin
      tick_at((m % 1440) * 60 + ((m == 7 * 60 + 31) ? 1 : 0));
      rang |= ringing;
    end
    chk("to quiet day", int'(rang), 0);
    tick_at(T(7, 30, 0));
    chk("to next day", int'(ringing), 1);

    // reset while ringing
    rst_n = 0;
    step(0, 0, 0);
    rst_n = 1;
    chk("rst mid ring",
        int'({ringing, buzz, snooze_act, snooze_cnt}), 0);

    // out-of-range alarm never rings over a day
    set_alm(25, 0);
    step(0, 0, 0);
    rang = 0;
    for (int m = 0; m < 1440; m++) begin
      tick_at(m * 60);
      rang |= ringing;
    end
    chk("bad hr quiet", int'(rang), 0);

    // random traffic against the reference model
    do_reset();
    chk_model = 1;
    set_time(T(6, 0, 0));
    almen = 1;
    set_alm(6, 2);
    for (int i = 0; i < 8000; i++) begin
      bit tk, sp, sz;
      int am;
      tk = (i % 2 == 0);
      if (tk) set_time((now + 1) % 86400);
      sp = ($urandom_range(0, 199) == 0);
      sz = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 999) == 0) almen = 0;
      else if (!almen && $urandom_range(0, 9) == 0) almen = 1;
      if (m_mode == 1 && $urandom_range(0, 299) == 0) begin
        am = (now / 60 + int'($urandom_range(1, 3))) % 1440;
        if ($urandom_range(0, 7) == 0)
          set_alm(24 + int'($urandom_range(0, 7)), am % 60);
        else
          set_alm(am / 60, am % 60);
      end
      step(tk, sp, sz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
